// File: rtl/rv32i_boot_ctrl.sv
// Boot sequencer for the single-cycle RV32I core: streams a length-prefixed
// byte image into imem, releases the core, then watches for a halt store or timeout.
module rv32i_boot_ctrl #(
   parameter int          IMEM_DEPTH = 1024,
   parameter int          ADDR_W     = 10,
   parameter logic [31:0] HALT_ADDR  = 32'hFFFF_FFF0,
   parameter int          MAX_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   input  logic              mem_write,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       write_data,
   output logic              done,
   output logic              timeout,
   output logic              err,
   output logic [31:0]       exit_code,
   output logic [31:0]       cycle_count
);

   localparam logic [2:0] ST_HDR  = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   localparam logic [31:0] DEPTH_W    = 32'(IMEM_DEPTH);
   localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [2:0]        state;
   logic [1:0]        byte_cnt;
   logic [23:0]       byte_buf;
   logic [ADDR_W-1:0] word_cnt;
   logic [ADDR_W-1:0] last_idx;
   logic [31:0]       word;
   logic              take;
   logic              word_end;
   logic              halt;

   assign in_ready   = (state == ST_HDR) || (state == ST_LOAD);
   assign core_rst_n = (state == ST_RUN);
   assign take       = in_valid && in_ready;
   assign word_end   = take && (byte_cnt == 2'd3);
   // The 4th byte is used straight off the bus so the word is complete on that edge.
   assign word       = {in_data, byte_buf};
   assign halt       = mem_write && (alu_result == HALT_ADDR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_HDR;
         byte_cnt    <= 2'd0;
         byte_buf    <= 24'd0;
         word_cnt    <= '0;
         last_idx    <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= 32'd0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         err         <= 1'b0;
         exit_code   <= 32'd0;
         cycle_count <= 32'd0;
      end else begin
         imem_we <= 1'b0;

         if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
               2'd0:    byte_buf[7:0]   <= in_data;
               2'd1:    byte_buf[15:8]  <= in_data;
               2'd2:    byte_buf[23:16] <= in_data;
               default: ;
            endcase
         end

         case (state)
            ST_HDR: begin
               if (word_end) begin
                  if (word == 32'd0) begin
                     state       <= ST_RUN;
                     cycle_count <= 32'd0;
                  end else if (word > DEPTH_W) begin
                     state <= ST_ERR;
                     err   <= 1'b1;
                  end else begin
                     state    <= ST_LOAD;
                     word_cnt <= '0;
                     last_idx <= word[ADDR_W-1:0] - ONE;
                  end
               end
            end
            ST_LOAD: begin
               if (word_end) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= word_cnt;
                  imem_wdata <= word;
                  word_cnt   <= word_cnt + ONE;
                  // Core leaves reset on the same edge as the final write.
                  if (word_cnt == last_idx) begin
                     state       <= ST_RUN;
                     cycle_count <= 32'd0;
                  end
               end
            end
            ST_RUN: begin
               cycle_count <= cycle_count + 32'd1;
               if (halt) begin
                  state     <= ST_DONE;
                  done      <= 1'b1;
                  exit_code <= write_data;
               end else if (cycle_count == LAST_CYCLE) begin
                  state   <= ST_DONE;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end
            end
            ST_DONE, ST_ERR: begin
               if (restart) begin
                  state       <= ST_HDR;
                  done        <= 1'b0;
                  timeout     <= 1'b0;
                  err         <= 1'b0;
                  exit_code   <= 32'd0;
                  cycle_count <= 32'd0;
                  byte_cnt    <= 2'd0;
               end
            end
            default: state <= ST_HDR;
         endcase
      end
   end

endmodule
